// File: rtl/qam64_pkg.sv
// Shared constants, level code type and level-to-float32 expansion for the
// 64-QAM hard-decision slicer.
package qam64_pkg;

  localparam logic [31:0] LVL1_F32 = 32'h3F80_0000;
  localparam logic [31:0] LVL3_F32 = 32'h4040_0000;
  localparam logic [31:0] LVL5_F32 = 32'h40A0_0000;
  localparam logic [31:0] LVL7_F32 = 32'h40E0_0000;

  localparam logic [31:0] THR2_F32 = 32'h4000_0000;
  localparam logic [31:0] THR4_F32 = 32'h4080_0000;
  localparam logic [31:0] THR6_F32 = 32'h40C0_0000;
  localparam logic [31:0] THR8_F32 = 32'h4100_0000;

  typedef enum logic [1:0] {
    L1 = 2'd0,
    L3 = 2'd1,
    L5 = 2'd2,
    L7 = 2'd3
  } lvl_e;

  function automatic logic [31:0] lvl_to_f32(input logic sign, input lvl_e lvl);
    logic [31:0] mag;
    unique case (lvl)
      L1:      mag = LVL1_F32;
      L3:      mag = LVL3_F32;
      L5:      mag = LVL5_F32;
      default: mag = LVL7_F32;
    endcase
    return {sign, mag[30:0]};
  endfunction

endpackage

// File: rtl/qam64_axis_slice.sv
// Combinational single-component slicer: float32 in, sign / level code / clip out.
module qam64_axis_slice
  import qam64_pkg::*;
(
  input  logic [31:0] i_x,
  output logic        o_sign,
  output lvl_e        o_lvl,
  output logic        o_clip
);

  // Magnitude bits of a non-NaN float order the same way as unsigned integers.
  logic [31:0] w_key;
  assign w_key = {1'b0, i_x[30:0]};

  always_comb begin
    o_lvl = L7;
    if (w_key < THR2_F32)      o_lvl = L1;
    else if (w_key < THR4_F32) o_lvl = L3;
    else if (w_key < THR6_F32) o_lvl = L5;
  end

  assign o_sign = i_x[31];
  assign o_clip = (w_key >= THR8_F32);

endmodule

// File: rtl/qam64_slicer.sv
// 64-QAM hard-decision slicer: two-stage valid/ready pipeline over a pair of
// component slicers, with wrapping symbol and saturating clip counters.
module qam64_slicer
  import qam64_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int CLIP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_re,
  input  logic [31:0]       in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_re,
  output logic [31:0]       out_im,
  output logic              out_clip,
  output logic [CNT_W-1:0]  sym_cnt,
  output logic [CLIP_W-1:0] clip_cnt
);

  function automatic logic [CLIP_W-1:0] sat_inc(input logic [CLIP_W-1:0] v,
                                                input logic inc);
    return (inc && (v != {CLIP_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

  logic w_sign_re, w_sign_im, w_clip_re, w_clip_im;
  lvl_e w_lvl_re, w_lvl_im;

  qam64_axis_slice u_slice_re (
    .i_x    (in_re),
    .o_sign (w_sign_re),
    .o_lvl  (w_lvl_re),
    .o_clip (w_clip_re)
  );

  qam64_axis_slice u_slice_im (
    .i_x    (in_im),
    .o_sign (w_sign_im),
    .o_lvl  (w_lvl_im),
    .o_clip (w_clip_im)
  );

  logic              r_vld_p1, r_sign_re_p1, r_sign_im_p1, r_clip_p1;
  lvl_e              r_lvl_re_p1, r_lvl_im_p1;
  logic              r_vld_p2, r_clip_p2;
  logic [31:0]       r_re_p2, r_im_p2;
  logic [CNT_W-1:0]  r_sym_cnt;
  logic [CLIP_W-1:0] r_clip_cnt;

  logic w_s2_adv, w_in_ready, w_acc, w_hs;
  assign w_s2_adv   = !r_vld_p2 || out_ready;
  assign w_in_ready = !r_vld_p1 || w_s2_adv;
  assign w_acc      = in_valid && w_in_ready;
  assign w_hs       = r_vld_p2 && out_ready;

  // Stage 1: level codes, signs and combined clip flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1     <= 1'b0;
      r_sign_re_p1 <= 1'b0;
      r_sign_im_p1 <= 1'b0;
      r_lvl_re_p1  <= L1;
      r_lvl_im_p1  <= L1;
      r_clip_p1    <= 1'b0;
    end else begin
      if (w_in_ready) r_vld_p1 <= in_valid;
      if (w_acc) begin
        r_sign_re_p1 <= w_sign_re;
        r_sign_im_p1 <= w_sign_im;
        r_lvl_re_p1  <= w_lvl_re;
        r_lvl_im_p1  <= w_lvl_im;
        r_clip_p1    <= w_clip_re || w_clip_im;
      end
    end
  end

  // Stage 2: expanded float32 outputs, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_re_p2   <= '0;
      r_im_p2   <= '0;
      r_clip_p2 <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_re_p2   <= lvl_to_f32(r_sign_re_p1, r_lvl_re_p1);
        r_im_p2   <= lvl_to_f32(r_sign_im_p1, r_lvl_im_p1);
        r_clip_p2 <= r_clip_p1;
      end
    end
  end

  // Statistics: clear wins over a same-cycle handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_cnt  <= '0;
      r_clip_cnt <= '0;
    end else if (clear) begin
      r_sym_cnt  <= '0;
      r_clip_cnt <= '0;
    end else if (w_hs) begin
      r_sym_cnt  <= r_sym_cnt + 1'b1;
      r_clip_cnt <= sat_inc(r_clip_cnt, r_clip_p2);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_vld_p2;
  assign out_re    = r_re_p2;
  assign out_im    = r_im_p2;
  assign out_clip  = r_clip_p2;
  assign sym_cnt   = r_sym_cnt;
  assign clip_cnt  = r_clip_cnt;

endmodule

// File: tb/tb_qam64_slicer.sv
// Scoreboard bench for qam64_slicer: a real-arithmetic reference model predicts
// each sliced symbol and the counter values; a negedge monitor compares.
module tb_qam64_slicer;

  localparam int CNT_W    = 32;
  localparam int CLIP_W   = 8;
  localparam int CLIP_MAX = (1 << CLIP_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_re = '0;
  logic [31:0]       in_im = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_re, out_im;
  logic              out_clip;
  logic [CNT_W-1:0]  sym_cnt;
  logic [CLIP_W-1:0] clip_cnt;

  qam64_slicer #(.CNT_W(CNT_W), .CLIP_W(CLIP_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_clip(out_clip),
    .sym_cnt(sym_cnt), .clip_cnt(clip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        clip;
    logic [31:0] re;
    logic [31:0] im;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_sym = 0;
  int   m_clip = 0;
  logic saw_stall = 1'b0;
  logic rnd_done = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic void fail(string nm);
    n_chk++;
    $display("FAIL %s", nm);
  endfunction

  function automatic real pow2(int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r * 0.5;
    return r;
  endfunction

  // Reference: decode the float to a real magnitude, pick the nearest level.
  function automatic logic [32:0] ref_axis(logic [31:0] x);
    logic [7:0]  e = x[30:23];
    logic [22:0] m = x[22:0];
    real         mag;
    int          lvl;
    logic        clip;
    logic [31:0] lv;
    if (e == 8'hFF) begin
      lvl = 7; clip = 1'b1;
    end else begin
      if (e == 8'h00) mag = real'(m) * pow2(-149);
      else            mag = (1.0 + real'(m) / 8388608.0) * pow2(int'(e) - 127);
      if (mag < 2.0)      lvl = 1;
      else if (mag < 4.0) lvl = 3;
      else if (mag < 6.0) lvl = 5;
      else                lvl = 7;
      clip = (mag >= 8.0);
    end
    case (lvl)
      1:       lv = 32'h3F80_0000;
      3:       lv = 32'h4040_0000;
      5:       lv = 32'h40A0_0000;
      default: lv = 32'h40E0_0000;
    endcase
    return {clip, x[31], lv[30:0]};
  endfunction

  function automatic exp_t model(logic [31:0] re, logic [31:0] im);
    logic [32:0] a = ref_axis(re);
    logic [32:0] b = ref_axis(im);
    exp_t e;
    e.clip = a[32] | b[32];
    e.re   = a[31:0];
    e.im   = b[31:0];
    return e;
  endfunction

  // Monitor: everything observed on the falling edge, acting for the next rise.
  always @(negedge clk) begin
    exp_t e;
    logic hs;
    if (!rst_n) begin
      q.delete();
      m_sym  = 0;
      m_clip = 0;
    end else begin
      hs = 1'b0;
      chk("sym_cnt", sym_cnt, m_sym);
      chk("clip_cnt", {24'd0, clip_cnt}, m_clip);
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && q.size() == 0) fail("unexpected_output");
      else if (out_valid && out_ready) begin
        e = q.pop_front();
        chk("out_re", out_re, e.re);
        chk("out_im", out_im, e.im);
        chk("out_clip", {31'd0, out_clip}, {31'd0, e.clip});
        hs = 1'b1;
      end
      if (clear) begin
        m_sym = 0; m_clip = 0;
      end else if (hs) begin
        m_sym = m_sym + 1;
        if (e.clip && m_clip != CLIP_MAX) m_clip = m_clip + 1;
      end
      if (in_valid && in_ready) q.push_back(model(in_re, in_im));
    end
  end

  task automatic send(input logic [31:0] re, input logic [31:0] im);
    int   n = 0;
    logic acc = 1'b0;
    in_valid = 1'b1; in_re = re; in_im = im;
    while (!acc && n < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!acc) fail("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) fail("drain_timeout");
  endtask

  task automatic one(input logic [31:0] re, input logic [31:0] im,
                     input logic [31:0] ere, input logic [31:0] eim, input logic eclip);
    send(re, im);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("dir_re", out_re, ere);
    chk("dir_im", out_im, eim);
    chk("dir_clip", {31'd0, out_clip}, {31'd0, eclip});
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
  endtask

  function automatic logic [31:0] gen_f32();
    logic [31:0] sp [16] = '{32'h4000_0000, 32'hC000_0000, 32'h4080_0000, 32'hC0C0_0000,
                             32'h40C0_0000, 32'h4100_0000, 32'hC100_0000, 32'h8000_0000,
                             32'h0000_0000, 32'h0000_0001, 32'h7F80_0000, 32'hFFC0_0000,
                             32'h7FFF_FFFF, 32'h40FF_FFFF, 32'h3FFF_FFFF, 32'h40BF_FFFF};
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1, 2:    return sp[$urandom_range(0, 15)];
      default: begin
        e = 8'($urandom_range(118, 132));
        return {1'($urandom), e, 23'($urandom)};
      end
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_re", out_re, 32'd0);
    chk("rst_out_im", out_im, 32'd0);
    chk("rst_out_clip", {31'd0, out_clip}, 32'd0);
    chk("rst_sym_cnt", sym_cnt, 32'd0);
    chk("rst_clip_cnt", {24'd0, clip_cnt}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    one(32'h3FC0_0000, 32'hC090_0000, 32'h3F80_0000, 32'hC0A0_0000, 1'b0);
    chk("first_sym_cnt", sym_cnt, 32'd1);
    one(32'h4000_0000, 32'hC0C0_0000, 32'h4040_0000, 32'hC0E0_0000, 1'b0);
    one(32'h8000_0000, 32'h0000_0001, 32'hBF80_0000, 32'h3F80_0000, 1'b0);
    one(32'h4100_0000, 32'h7FC0_0000, 32'h40E0_0000, 32'h40E0_0000, 1'b1);
    chk("first_clip_cnt", {24'd0, clip_cnt}, 32'd1);

    // clear coinciding with a clipped handshake
    send(32'h4100_0000, 32'h0000_0000);
    @(posedge clk); #1;
    clear = 1'b1;
    chk("clr_hs_valid", {31'd0, out_valid}, 32'd1);
    chk("clr_hs_clip", {31'd0, out_clip}, 32'd1);
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_sym_cnt", sym_cnt, 32'd0);
    chk("clr_clip_cnt", {24'd0, clip_cnt}, 32'd0);

    // saturate the clip counter
    for (int i = 0; i < CLIP_MAX + 5; i++) send(32'hC1A0_0000, 32'h3F00_0000);
    drain();
    chk("sat_clip_cnt", {24'd0, clip_cnt}, CLIP_MAX);
    chk("sat_sym_cnt", sym_cnt, CLIP_MAX + 5);

    // backpressure mid-stream
    do_clear();
    saw_stall = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(gen_f32(), gen_f32());
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_sym_cnt", sym_cnt, 32'd8);
    chk("bp_in_ready_dropped", {31'd0, saw_stall}, 32'd1);

    // randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(gen_f32(), gen_f32());
        end
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    out_ready = 1'b1;
    drain();

    // asynchronous reset with two samples in flight
    out_ready = 1'b0;
    send(32'h3FC0_0000, 32'h4100_0000);
    send(32'hC0A0_0000, 32'h3F80_0000);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_re", out_re, 32'd0);
    chk("arst_sym_cnt", sym_cnt, 32'd0);
    chk("arst_clip_cnt", {24'd0, clip_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("arst_no_stale", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
